// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: captures core output changes into a FIFO and releases them to the DAC at a fixed rate.
// A code is queued once per change. Queued codes are popped on rate ticks. Overflow and underflow are sticky flags.
module dac_sample_pacer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [DATA_W-1:0]        core_out,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     clr_flags,
    output logic [DATA_W-1:0]        dac_d,
    output logic                     dac_upd,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    output logic                     unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] last_in_q, dac_code_q, dac_code_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, n;
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              upd_q, ovf_q, ovf_d, unf_q, unf_d;
    logic              tick, empty, full, push, pop, wr_en;

    assign n     = (rate_div == '0) ? DIV_W'(1) : rate_div;
    assign tick  = en && (cnt_q >= n - DIV_W'(1));
    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign push  = en && (core_out != last_in_q);
    // emptiness is judged before this cycle's push, so a push never bypasses to the DAC
    assign pop   = tick && !empty;
    assign wr_en = push && (!full || pop);

    always_comb begin
        cnt_d      = (!en || tick) ? '0 : cnt_q + 1'b1;
        rd_d       = rd_q + AW'(pop);
        wr_d       = wr_q + AW'(wr_en);
        level_d    = level_q + LW'(wr_en) - LW'(pop);
        dac_code_d = pop ? mem_q[rd_q] : dac_code_q;
        ovf_d      = (push && full && !pop) || (ovf_q && !clr_flags);
        unf_d      = (tick && empty) || (unf_q && !clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_in_q  <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            dac_code_q <= '0;
            upd_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            last_in_q  <= core_out;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            dac_code_q <= dac_code_d;
            upd_q      <= pop;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= core_out;
    end

    assign dac_d      = dac_code_q;
    assign dac_upd    = upd_q;
    assign fifo_level = level_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: directed checks of pacing, hold/underflow, overflow, full push+pop, reset and enable.
module tb_dac_sample_pacer;
    logic        clk = 1'b0;
    logic        reset, en, clr_flags;
    logic [9:0]  core_out;
    logic [15:0] rate_div;
    logic [9:0]  dac_d;
    logic        dac_upd, ovf, unf;
    logic [3:0]  fifo_level;
    int          n_cmp = 0;
    int          n_bad = 0;

    dac_sample_pacer dut (
        .clk(clk), .reset(reset), .en(en), .core_out(core_out), .rate_div(rate_div),
        .clr_flags(clr_flags), .dac_d(dac_d), .dac_upd(dac_upd), .fifo_level(fifo_level),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        en = 1'b0;
        core_out = '0;
        clr_flags = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        rate_div = 16'd4;
        do_reset();
        chk("rst_dac", dac_d, 0);
        chk("rst_upd", dac_upd, 0);
        chk("rst_lvl", fifo_level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);

        // pacing at rate_div=4: ticks on the 4th, 8th, 12th, 16th edges
        en = 1'b1;
        core_out = 10'd5;  step(1);
        core_out = 10'd9;  step(1);
        core_out = 10'd12; step(1);
        chk("pace_lvl3", fifo_level, 3);
        chk("pace_dac0", dac_d, 0);
        step(1);
        chk("pace_dac5", dac_d, 5);
        chk("pace_upd5", dac_upd, 1);
        chk("pace_lvl2", fifo_level, 2);
        step(1);
        chk("pace_upd_lo", dac_upd, 0);
        step(3);
        chk("pace_dac9", dac_d, 9);
        chk("pace_upd9", dac_upd, 1);
        step(4);
        chk("pace_dac12", dac_d, 12);
        chk("pace_lvl0", fifo_level, 0);
        chk("pace_unf0", unf, 0);
        step(4);
        chk("pace_unf1", unf, 1);
        chk("pace_upd_empty", dac_upd, 0);
        chk("pace_hold12", dac_d, 12);

        // asynchronous reset with a queued sample
        core_out = 10'd33; step(1);
        chk("mid_lvl1", fifo_level, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_dac", dac_d, 0);
        chk("arst_lvl", fifo_level, 0);
        chk("arst_unf", unf, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_upd", dac_upd, 0);
        do_reset();

        // underflow and zero-order hold at rate_div=3
        rate_div = 16'd3;
        en = 1'b1;
        core_out = 10'h3FF;
        step(2);
        chk("unf_dac0", dac_d, 0);
        step(1);
        chk("unf_dac3ff", dac_d, 10'h3FF);
        chk("unf_upd", dac_upd, 1);
        step(1);
        chk("unf_upd_lo", dac_upd, 0);
        chk("unf_not_yet", unf, 0);
        step(2);
        chk("unf_set", unf, 1);
        chk("unf_upd_hold", dac_upd, 0);
        chk("unf_hold", dac_d, 10'h3FF);

        // overflow: 10 codes into 8 entries, no ticks
        do_reset();
        rate_div = 16'd1000;
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            core_out = 10'(i);
            step(1);
            if (i == 8) chk("ovf_pre", ovf, 0);
            if (i == 9) chk("ovf_at9", ovf, 1);
        end
        chk("ovf_lvl8", fifo_level, 8);
        chk("ovf_set", ovf, 1);
        clr_flags = 1'b1;
        core_out = 10'd11;
        step(1);
        chk("ovf_set_wins", ovf, 1);
        chk("ovf_lvl_still8", fifo_level, 8);
        step(1);
        chk("ovf_clr", ovf, 0);
        clr_flags = 1'b0;
        rate_div = 16'd0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("drain_dac", dac_d, i);
            chk("drain_upd", dac_upd, 1);
        end
        step(1);
        chk("drain_unf", unf, 1);
        chk("drain_upd_lo", dac_upd, 0);
        chk("drain_hold", dac_d, 8);
        chk("drain_lvl0", fifo_level, 0);

        // full FIFO with push and pop on the same tick
        do_reset();
        rate_div = 16'd10;
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            core_out = 10'(i);
            step(1);
        end
        step(1);
        chk("fpp_full", fifo_level, 8);
        core_out = 10'h55;
        step(1);
        chk("fpp_lvl8", fifo_level, 8);
        chk("fpp_ovf0", ovf, 0);
        chk("fpp_dac1", dac_d, 1);
        chk("fpp_upd", dac_upd, 1);
        rate_div = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("fpp_order", dac_d, (i < 7) ? i + 2 : 32'h55);
        end
        chk("fpp_empty", fifo_level, 0);

        // en=0 freezes FIFO and restarts the rate counter from zero
        do_reset();
        rate_div = 16'd4;
        en = 1'b1;
        core_out = 10'd7;
        step(2);
        en = 1'b0;
        core_out = 10'd8;  step(1);
        core_out = 10'd9;  step(1);
        core_out = 10'd10; step(1);
        chk("en0_lvl", fifo_level, 1);
        chk("en0_dac", dac_d, 0);
        chk("en0_upd", dac_upd, 0);
        en = 1'b1;
        step(3);
        chk("en1_no_tick", dac_d, 0);
        step(1);
        chk("en1_tick_dac", dac_d, 7);
        chk("en1_tick_upd", dac_upd, 1);
        chk("en1_lvl0", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
